// File: rtl/cpu4_trace_fifo.sv
// Trace recorder for the 4-bit CPU: captures {halt, pc, r0..r3} on every pc change
// (and once on halt) into a FIFO drained over a valid/ready handshake.
module cpu4_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_en,
    input  logic [3:0]    pc,
    input  logic [3:0]    r0,
    input  logic [3:0]    r1,
    input  logic [3:0]    r2,
    input  logic [3:0]    r3,
    input  logic          halt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [20:0]   out_data,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   prev_pc_q, prev_pc_d;
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         overflow_q, overflow_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;
    logic [20:0]  mem_q [DEPTH];

    logic         capture_s;
    logic         push_s;
    logic         pop_s;
    logic         drop_s;
    logic         full_s;
    logic         empty_s;
    logic [AW:0]  count_s;
    logic [20:0]  sample_s;

    assign sample_s = {halt, pc, r0, r1, r2, r3};
    assign count_s  = wptr_q - rptr_q;
    assign empty_s  = (count_s == (AW+1)'(0));
    assign full_s   = (count_s == (AW+1)'(DEPTH));

    // Capture FSM: cap_en low always wins over a pending capture condition
    always_comb begin
        state_d   = state_q;
        prev_pc_d = prev_pc_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_en) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (!cap_en) begin
                    state_d = IDLE;
                end else begin
                    capture_s = 1'b1;
                    prev_pc_d = pc;
                    state_d   = halt ? HALTED : RUN;
                end
            end
            RUN: begin
                if (!cap_en) begin
                    state_d = IDLE;
                end else if ((pc != prev_pc_q) || halt) begin
                    capture_s = 1'b1;
                    prev_pc_d = pc;
                    state_d   = halt ? HALTED : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and drop accounting; a pop frees the slot a full-FIFO push needs
    always_comb begin
        pop_s      = (!empty_s) && out_ready;
        push_s     = capture_s && ((!full_s) || pop_s);
        drop_s     = capture_s && full_s && (!pop_s);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (push_s) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end else begin
            rptr_d = rptr_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_pc_q  <= 4'd0;
            wptr_q     <= {(AW+1){1'b0}};
            rptr_q     <= {(AW+1){1'b0}};
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_pc_q  <= prev_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents are only observable through the occupied window
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q[AW-1:0]] <= sample_s;
        end
    end

    assign out_valid = !empty_s;
    assign out_data  = empty_s ? {21{1'b0}} : mem_q[rptr_q[AW-1:0]];
    assign count     = count_s;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign done      = (state_q == HALTED);

endmodule

// File: tb/tb_cpu4_trace_fifo.sv
// Scoreboard bench for cpu4_trace_fifo: directed CPU trace vectors, expected entries
// queued at stimulus time and checked by an independent output monitor.
module tb_cpu4_trace_fifo;

    logic        clk;
    logic        reset;
    logic        cap_en;
    logic [3:0]  pc, r0, r1, r2, r3;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];
    logic        stall_v = 1'b0;
    logic [20:0] stall_d = 21'd0;

    cpu4_trace_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .cap_en(cap_en), .pc(pc),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One CPU sample, sampled by the DUT at the next rising edge
    task automatic drive(input logic [3:0] p, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input logic h, input bit exp);
        @(posedge clk);
        #1;
        pc = p; r0 = a; r1 = b; r2 = c; r3 = d; halt = h;
        if (exp) exp_q.push_back({h, p, a, b, c, d});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual=%0d_left expected=0_left", name, exp_q.size());
        end
        tick(2);
        chk({name, "_empty_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b0; cap_en = 1'b0; halt = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick(2);
        reset = 1'b1;
    endtask

    // Monitor: every accepted head entry must match the next expected entry
    always @(negedge clk) begin
        if (!reset) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                checks++;
                if (!out_valid || out_data !== stall_d) begin
                    errors++;
                    $display("FAIL stall_hold actual=%0b/%0h expected=1/%0h", out_valid, out_data, stall_d);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL entry actual=%0h expected=none", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL entry actual=%0h expected=%0h", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            stall_v = out_valid && !out_ready;
            stall_d = out_data;
        end
    end

    initial begin
        reset = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
        pc = 4'd0; r0 = 4'd0; r1 = 4'd0; r2 = 4'd0; r3 = 4'd0; halt = 1'b0;

        // Reset hold, then release with capture disarmed
        tick(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(4'(i), 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data", 32'(out_data), 32'd0);

        // CPU program with out_ready held high
        cap_en = 1'b1;
        drive(4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        drive(4'd1, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        drive(4'd2, 4'h3, 4'h5, 4'h0, 4'h0, 1'b0, 1'b1);
        drive(4'd3, 4'h3, 4'h5, 4'h2, 4'h0, 1'b0, 1'b1);
        drive(4'd4, 4'h3, 4'h5, 4'h2, 4'h1, 1'b0, 1'b1);
        drive(4'd5, 4'h8, 4'h5, 4'h2, 4'h1, 1'b0, 1'b1);
        drive(4'd6, 4'h8, 4'h7, 4'h2, 4'h1, 1'b0, 1'b1);
        drive(4'd7, 4'h8, 4'h7, 4'h2, 4'h9, 1'b0, 1'b1);
        drive(4'd8, 4'hF, 4'h7, 4'h2, 4'h9, 1'b0, 1'b1);
        drive(4'd9, 4'hF, 4'h8, 4'h2, 4'h9, 1'b0, 1'b1);
        drive(4'd9, 4'hF, 4'h8, 4'h2, 4'h9, 1'b1, 1'b1);
        tick(3);
        chk("prog_done", 32'(done), 32'd1);
        chk("prog_overflow", 32'(overflow), 32'd0);
        wait_drain("prog");

        // Overflow: 20 captures into 16 slots with the consumer stalled
        do_reset();
        tick(1);
        cap_en = 1'b1;
        for (int k = 0; k < 20; k++)
            drive(4'(k), 4'(k), 4'(k + 3), 4'hA, 4'h5, 1'b0, k < 16);
        tick(1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_valid", 32'(out_valid), 32'd1);

        // Full FIFO, push coinciding with a pop is accepted
        drive(4'd4, 4'h4, 4'h7, 4'hA, 4'h5, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick(1);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_drop", 32'(drop_cnt), 32'd4);
        wait_drain("ovf");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Halt held for several cycles yields a single halt entry
        do_reset();
        tick(1);
        cap_en = 1'b1;
        out_ready = 1'b1;
        drive(4'd2, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b1);
        drive(4'd3, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b1);
        drive(4'd3, 4'h5, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(4'd3, 4'h5, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(4'(i + 7), 4'(i), 4'(~i), 4'(i * 3), 4'h1, 1'(i), 1'b0);
        tick(2);
        chk("halt_done", 32'(done), 32'd1);
        wait_drain("halt");
        chk("halt_count", 32'(count), 32'd0);

        // Asynchronous reset mid-run discards entries and returns to IDLE
        do_reset();
        tick(1);
        cap_en = 1'b1;
        for (int k = 0; k < 7; k++) drive(4'(k), 4'(k), 4'h1, 4'h2, 4'h3, 1'b0, 1'b1);
        tick(1);
        chk("mid_count", 32'(count), 32'd7);
        chk("mid_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        pc = 4'd5; r0 = 4'h1; r1 = 4'h2; r2 = 4'h3; r3 = 4'h4; halt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1);
        chk("post_idle_count", 32'(count), 32'd0);
        exp_q.push_back({1'b0, 4'd5, 4'h1, 4'h2, 4'h3, 4'h4});
        tick(1);
        chk("post_arm_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        wait_drain("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu4_trace_fifo.md
Name: cpu4_trace_fifo

Overview:
- Downstream observer of the 4-bit CPU core. Samples the core's architectural outputs (pc, r0..r3, halt) every clock.
- Records one trace entry per retired instruction, i.e. each time pc changes, plus one final entry when halt asserts.
- Buffers entries in a FIFO and drains them to a debug consumer over a valid/ready handshake.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cap_en  input  1  capture enable; trace recording is armed while high.
- pc  input  4  CPU program counter.
- r0  input  4  CPU register R0.
- r1  input  4  CPU register R1.
- r2  input  4  CPU register R2.
- r3  input  4  CPU register R3.
- halt  input  1  CPU halt flag.
- out_valid  output  1  FIFO head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  21  head entry, packed {halt, pc, r0, r1, r2, r3}, MSB first.
- count  output  AW+1  number of occupied entries.
- overflow  output  1  sticky flag: at least one entry was dropped.
- drop_cnt  output  8  number of dropped entries; saturates at 255.
- done  output  1  halt entry has been captured.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, count=0, overflow=0, drop_cnt=0, done=0.
  - Pointers cleared; prev_pc=0; FSM enters IDLE.
  - Reset mid-operation discards all entries immediately.
- FSM states:
  - IDLE: no captures. Moves to ARM on the first clock edge where cap_en=1.
  - ARM: captures the current sample unconditionally (first entry), loads prev_pc=pc, then moves to RUN. If halt=1 in that sample, the entry carries the halt bit and the FSM moves to HALTED instead.
  - RUN:
    - capture when pc != prev_pc, or when halt=1.
    - After a capture, prev_pc=pc.
    - A capture with halt=1 moves the FSM to HALTED.
    - cap_en=0 returns the FSM to IDLE without a capture; FIFO contents are retained.
  - HALTED: done=1, no further captures. Leaves only via reset.
- Capture timing:
  - Inputs are sampled at rising edge N.
  - The entry is written at edge N.
  - out_valid rises after edge N if the FIFO was empty; one-cycle latency.
- Output side:
  - out_data shows the head entry whenever out_valid=1, and holds 0 when the FIFO is empty.
  - The head advances on any edge where out_valid=1 and out_ready=1.
  - out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- Full / empty:
  - Push while full with no simultaneous pop: the entry is dropped, overflow is set (sticky), and drop_cnt increments, saturating at 255.
  - A dropped halt capture still moves the FSM to HALTED and still sets done.
  - Push while full with a simultaneous pop: the push is accepted and count is unchanged.
  - Pop while empty: ignored.
  - Push and pop in the same cycle while non-empty and non-full: count is unchanged.
- Pointers wrap modulo DEPTH. count = write pointer minus read pointer using AW+1-bit pointers; full when count==DEPTH.
- A capture condition true in the same cycle as cap_en falling: no capture; cap_en=0 takes priority.

Test Plan:
- Reset hold, then release with cap_en=0 and pc stepping 0..3 -> no entries, out_valid=0, count=0, all outputs 0.
- cap_en=1. CPU program: MOV R0,3; MOV R1,5; MOV R2,2; MOV R3,1; ADD R0,R1; ADD R1,R2; ADD R3,R0; SUB R0,R3; SUB R1,R0; HLT. out_ready=1 throughout -> entries drained in order, final entry {1, pc, r0=F, r1=8, r2=2, r3=9}, done=1, overflow=0.
- out_ready=0, DEPTH=16, 20 pc changes -> count=16, overflow=1, drop_cnt=4. Then out_ready=1 -> exactly 16 entries drained, first entry equals the ARM sample.
- FIFO full with out_ready=1 while a new pc arrives -> push accepted, count stays 16, drop_cnt unchanged.
- halt=1 held for 5 cycles, pc constant -> exactly one halt entry; no further entries while pc and registers keep toggling.
- Assert reset=0 mid-run with count=7, out_valid=1 -> out_valid drops immediately (asynchronously), count=0, done=0. After release, the FSM is in IDLE.
